if_mem_arbiter: RTL and testbench
=================================

Name: if_mem_arbiter

Overview:
- Shares the single CPU-side bus port between the instruction fetch stage and the memory-access stage.
- Two-state-plus-idle FSM grants one requester at a time. MEM has priority over IF, because MEM belongs to the older instruction.
- Produces per-stage busy signals that feed the pipeline stall logic.
- Supports squashing an in-flight fetch on pipeline flush without aborting the bus cycle.

Parameters:
- ADDR_W, 30, word address width (matches WordAddrBus).
- DATA_W, 32, data width (matches WordDataBus).
- TIMEOUT, 255, bus_rdy watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level; held until if_rdy
- if_addr  in  ADDR_W  fetch word address
- if_flush  in  1  squash any pending or in-flight fetch
- if_rdata  out  DATA_W  fetched instruction
- if_rdy  out  1  fetch complete, 1-cycle pulse
- if_busy  out  1  IF must stall
- mem_req  in  1  data request, level; held until mem_rdy
- mem_rw  in  1  1 = write, 0 = read
- mem_addr  in  ADDR_W  data word address
- mem_wdata  in  DATA_W  write data
- mem_rdata  out  DATA_W  read data
- mem_rdy  out  1  access complete, 1-cycle pulse
- mem_busy  out  1  MEM must stall
- bus_req  out  1  bus cycle active (registered)
- bus_rw  out  1  registered
- bus_addr  out  ADDR_W  registered
- bus_wdata  out  DATA_W  registered
- bus_rdata  in  DATA_W  bus read data
- bus_rdy  in  1  bus cycle done, 1-cycle pulse
- bus_err  out  1  watchdog timeout pulse (tied 0 without the optional feature)

Behaviour:
- Reset values:
  - state = IDLE.
  - All bus_* outputs = 0.
  - if_rdy, mem_rdy, bus_err = 0.
  - discard flag = 0; watchdog counter = 0.
  - if_rdata and mem_rdata are don't-care; they pass bus_rdata through combinationally.
- States:
  - IDLE
    - mem_req → MEM_ACC.
    - Else if_req && !if_flush → IF_ACC.
    - Bus outputs are latched from the granted requester on that same edge.
  - IF_ACC: wait for bus_rdy.
    - if_rdy = bus_rdy && !discard.
    - On bus_rdy → IDLE.
  - MEM_ACC: wait for bus_rdy.
    - mem_rdy = bus_rdy.
    - On bus_rdy → IDLE.
- Latency:
  - Request seen in IDLE → bus_req high next cycle.
  - Minimum access time is 2 cycles: request to rdy with zero bus wait states.
  - A mandatory 1-cycle IDLE between accesses. There are no back-to-back grants.
- bus_req clears on the edge after bus_rdy.
- Bus outputs are stable for the entire access.
- Busy signals:
  - if_busy = if_req && !if_rdy.
  - mem_busy = mem_req && !mem_rdy.
- Simultaneous if_req and mem_req in IDLE: MEM is granted. IF waits at least until the IDLE following MEM completion.
- if_flush during IF_ACC:
  - The bus cycle completes; it is never aborted.
  - discard is set and if_rdy is suppressed for that access.
  - discard clears on return to IDLE.
- if_flush in IDLE: no IF grant that cycle.
- if_flush together with bus_rdy in IF_ACC: if_rdy is suppressed.
- The arbiter ignores requester input changes while their access is in flight. Requesters must hold their address and data.
- rst during an access: state returns to IDLE and bus_req drops on that edge. Any in-flight bus transaction is abandoned.

Optional Feature:
- Macro: IF_MEM_ARB_TIMEOUT_EN.
- Enabled:
  - A counter increments each cycle in IF_ACC or MEM_ACC without bus_rdy.
  - When it reaches TIMEOUT: assert bus_err for 1 cycle, pulse the owner's rdy with rdata forced to 0, go to IDLE, and clear the counter.
  - The counter clears on every grant.
- Disabled: no counter exists, bus_err is constant 0, and an access may wait indefinitely.

Decomposition:
- Shared package:
  - State enum arb_state_t {ARB_IDLE, ARB_IF, ARB_MEM}.
  - ADDR_W/DATA_W defaults tied to the WordAddrBus/WordDataBus widths.
  - Read/write encoding constants.
- One natural sub-module: if_mem_arb_watchdog, the timeout counter, instantiated only under IF_MEM_ARB_TIMEOUT_EN.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x10, bus_rdy after 0 wait states with bus_rdata=0x12345678 → bus_addr=0x10 next cycle, if_rdy on the 2nd cycle with if_rdata=0x12345678, if_busy low afterwards.
- Contention: if_req and mem_req rise together, mem_rw=1, mem_addr=0x40, mem_wdata=0xDEADBEEF → MEM granted first, bus_rw=1; IF granted one IDLE cycle after mem_rdy; if_busy high throughout.
- Flush in flight: IF_ACC with 3 bus wait states, if_flush pulsed in wait cycle 1 → bus cycle completes, if_rdy stays 0, FSM reaches IDLE.
- Reset mid-access: assert rst during MEM_ACC → bus_req=0 and state=IDLE on the next edge; a later mem_req is granted normally.
- Wait states: bus_rdy withheld for 5 cycles → bus_addr and bus_wdata constant all 5 cycles, mem_busy=1 until the mem_rdy pulse.
- Timeout (macro on, TIMEOUT=4): bus_rdy never asserted → bus_err pulses in the 4th wait cycle, if_rdy pulses with if_rdata=0, FSM reaches IDLE.

Source files
------------

// File: rtl/if_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// if_mem_arbiter_pkg
// Shared definitions for the IF/MEM bus arbiter slice:
//   - default word address/data widths (WordAddrBus / WordDataBus)
//   - bus read/write encoding
//   - arbiter state enumeration
//   - grant-detection helper
// -----------------------------------------------------------------------------
package if_mem_arbiter_pkg;

  localparam int unsigned WORD_ADDR_W = 30;  // WordAddrBus width
  localparam int unsigned WORD_DATA_W = 32;  // WordDataBus width

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_IF   = 2'd1,
    ARB_MEM  = 2'd2
  } arb_state_t;

  // A grant is the step out of IDLE into either access state.
  function automatic logic is_grant(input arb_state_t cur, input arb_state_t nxt);
    return (cur == ARB_IDLE) && (nxt != ARB_IDLE);
  endfunction

endpackage

// File: rtl/if_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// if_mem_arbiter_if
// Bundles the fetch port, the data-access port and the shared CPU bus port.
//   modport master : the arbiter's view (it owns the shared bus)
//   modport slave  : the environment's view (requesters + bus responder)
// Parameters ADDR_W / DATA_W must match the arbiter instance.
// -----------------------------------------------------------------------------
interface if_mem_arbiter_if
  import if_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = WORD_ADDR_W,
  parameter int unsigned DATA_W = WORD_DATA_W
);

  // Instruction fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_rdy;
  logic              if_busy;

  // Memory access port
  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rdy;
  logic              mem_busy;

  // Shared CPU bus port
  logic              bus_req;
  logic              bus_rw;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rdy;
  logic              bus_err;

  modport master (
    input  if_req, if_addr, if_flush,
    output if_rdata, if_rdy, if_busy,
    input  mem_req, mem_rw, mem_addr, mem_wdata,
    output mem_rdata, mem_rdy, mem_busy,
    output bus_req, bus_rw, bus_addr, bus_wdata, bus_err,
    input  bus_rdata, bus_rdy
  );

  modport slave (
    output if_req, if_addr, if_flush,
    input  if_rdata, if_rdy, if_busy,
    output mem_req, mem_rw, mem_addr, mem_wdata,
    input  mem_rdata, mem_rdy, mem_busy,
    input  bus_req, bus_rw, bus_addr, bus_wdata, bus_err,
    output bus_rdata, bus_rdy
  );

endinterface

// File: rtl/if_mem_arb_watchdog.sv
// -----------------------------------------------------------------------------
// if_mem_arb_watchdog
// Bus_rdy watchdog for the IF/MEM arbiter; only built with
// IF_MEM_ARB_TIMEOUT_EN defined.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   active_i    an access is in flight
//   bus_rdy_i   bus cycle done
//   clear_i     grant: restart the count
//   expired_o   combinational: this is the TIMEOUT-th cycle without bus_rdy
// -----------------------------------------------------------------------------
`ifdef IF_MEM_ARB_TIMEOUT_EN
module if_mem_arb_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active_i,
  input  logic bus_rdy_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  // The count holds the number of wait cycles already elapsed, so the
  // TIMEOUT-th wait cycle is the one that sees TIMEOUT-1.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expired_s;

  assign expired_s = active_i && !bus_rdy_i && (cnt_q == LIMIT);
  assign expired_o = expired_s;

  // Next count: clear on grant or expiry, advance on each unanswered cycle.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i || expired_s) begin
      cnt_d = '0;
    end else if (active_i && !bus_rdy_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`endif

// File: rtl/if_mem_arbiter.sv
// -----------------------------------------------------------------------------
// if_mem_arbiter
// Shares the single CPU bus port between instruction fetch (IF) and memory
// access (MEM). MEM wins ties because it belongs to the older instruction.
// Every access is followed by one IDLE cycle; bus_* outputs are registered
// and held for the whole access. A fetch flushed in flight still completes
// on the bus, but its if_rdy is swallowed.
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   bus       if_mem_arbiter_if.master: fetch port, data port, shared bus
// Optional: define IF_MEM_ARB_TIMEOUT_EN to add a bus_rdy watchdog that ends
// an access after TIMEOUT unanswered cycles with bus_err and a zero rdata.
// -----------------------------------------------------------------------------
module if_mem_arbiter
  import if_mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = WORD_ADDR_W,
  parameter int unsigned DATA_W  = WORD_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  if_mem_arbiter_if.master     bus
);

  arb_state_t        state_q,     state_d;
  logic              discard_q,   discard_d;
  logic              bus_req_q,   bus_req_d;
  logic              bus_rw_q,    bus_rw_d;
  logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

  logic              timeout_s;
  logic              done_s;
  logic              if_rdy_s;
  logic              mem_rdy_s;

`ifdef IF_MEM_ARB_TIMEOUT_EN
  logic grant_s;
  logic active_s;

  assign grant_s  = is_grant(state_q, state_d);
  assign active_s = (state_q != ARB_IDLE);

  if_mem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .active_i  (active_s),
    .bus_rdy_i (bus.bus_rdy),
    .clear_i   (grant_s),
    .expired_o (timeout_s)
  );
`else
  // No watchdog: an access waits for bus_rdy indefinitely.
  assign timeout_s = (TIMEOUT == 32'd0) & 1'b0;
`endif

  // A watchdog expiry ends the access exactly like a bus_rdy would.
  assign done_s    = bus.bus_rdy | timeout_s;
  // Flush in the completion cycle also suppresses the fetch result.
  assign if_rdy_s  = (state_q == ARB_IF) && done_s && !discard_q && !bus.if_flush;
  assign mem_rdy_s = (state_q == ARB_MEM) && done_s;

  assign bus.if_rdy    = if_rdy_s;
  assign bus.mem_rdy   = mem_rdy_s;
  assign bus.if_busy   = bus.if_req && !if_rdy_s;
  assign bus.mem_busy  = bus.mem_req && !mem_rdy_s;
  assign bus.if_rdata  = timeout_s ? '0 : bus.bus_rdata;
  assign bus.mem_rdata = timeout_s ? '0 : bus.bus_rdata;
  assign bus.bus_err   = timeout_s;
  assign bus.bus_req   = bus_req_q;
  assign bus.bus_rw    = bus_rw_q;
  assign bus.bus_addr  = bus_addr_q;
  assign bus.bus_wdata = bus_wdata_q;

  // Arbitration FSM next-state and bus output latching.
  always_comb begin
    state_d     = state_q;
    discard_d   = discard_q;
    bus_req_d   = bus_req_q;
    bus_rw_d    = bus_rw_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    case (state_q)
      ARB_IDLE: begin
        discard_d = 1'b0;
        if (bus.mem_req) begin
          state_d     = ARB_MEM;
          bus_req_d   = 1'b1;
          bus_rw_d    = bus.mem_rw;
          bus_addr_d  = bus.mem_addr;
          bus_wdata_d = bus.mem_wdata;
        end else if (bus.if_req && !bus.if_flush) begin
          state_d     = ARB_IF;
          bus_req_d   = 1'b1;
          bus_rw_d    = BUS_READ;
          bus_addr_d  = bus.if_addr;
          bus_wdata_d = '0;
        end else begin
          state_d = ARB_IDLE;
        end
      end
      ARB_IF, ARB_MEM: begin
        if (done_s) begin
          // Back to IDLE; the next grant cannot happen before the next edge.
          state_d     = ARB_IDLE;
          discard_d   = 1'b0;
          bus_req_d   = 1'b0;
          bus_rw_d    = 1'b0;
          bus_addr_d  = '0;
          bus_wdata_d = '0;
        end else if ((state_q == ARB_IF) && bus.if_flush) begin
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
      end
      default: begin
        state_d     = ARB_IDLE;
        discard_d   = 1'b0;
        bus_req_d   = 1'b0;
        bus_rw_d    = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
      end
    endcase
  end

  // State and registered bus outputs; reset abandons any in-flight access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      discard_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      bus_rw_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      bus_req_q   <= bus_req_d;
      bus_rw_q    <= bus_rw_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

endmodule

// File: tb/tb_if_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_if_mem_arbiter
// Self-checking bench for if_mem_arbiter: a table of single accesses plus
// hand-written sequences for contention, flush, reset and watchdog cases.
// Expected bus transactions are queued when a request is raised and checked
// when the arbiter starts the bus cycle; inputs change and outputs are
// sampled around the falling clock edge.
// -----------------------------------------------------------------------------
module tb_if_mem_arbiter;
  import if_mem_arbiter_pkg::*;

`ifdef IF_MEM_ARB_TIMEOUT_EN
  localparam int LONG_W = 2;  // stay below the 4-cycle watchdog
`else
  localparam int LONG_W = 5;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_mem_arbiter_if ifc ();

  if_mem_arbiter #(
    .ADDR_W  (30),
    .DATA_W  (32),
    .TIMEOUT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
  } bus_txn_t;

  typedef struct {
    logic        is_mem;
    logic        rw;
    logic [29:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] rdata;
    int          exp_lat;
  } vec_t;

  bus_txn_t exp_q[$];

  // Bus responder controls
  int          bus_waits = 0;
  logic        bus_stall = 1'b0;
  logic [31:0] bus_resp  = 32'h0;
  int          bus_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic rw, input logic [29:0] addr, input logic [31:0] wdata);
    bus_txn_t t;
    t.rw = rw; t.addr = addr; t.wdata = wdata;
    exp_q.push_back(t);
  endtask

  // Bus responder: answers bus_waits cycles after bus_req is first seen.
  always @(negedge clk) begin
    ifc.bus_rdy = 1'b0;
    if (rst || ifc.bus_req !== 1'b1) begin
      bus_cnt = 0;
    end else if (bus_cnt >= bus_waits && !bus_stall) begin
      ifc.bus_rdy   = 1'b1;
      ifc.bus_rdata = bus_resp;
      bus_cnt       = 0;
    end else begin
      bus_cnt++;
    end
  end

  // Bus monitor: checks each new bus cycle against the scoreboard and its
  // stability for as long as bus_req stays high.
  logic     mon_prev = 1'b0;
  bus_txn_t mon_cur;
  always @(negedge clk) begin
    if (ifc.bus_req === 1'b1 && !mon_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL bus_grant: unexpected bus cycle addr %h", ifc.bus_addr);
      end else begin
        mon_cur = exp_q.pop_front();
        check("bus_rw", {31'h0, ifc.bus_rw}, {31'h0, mon_cur.rw});
        check("bus_addr", {2'b00, ifc.bus_addr}, {2'b00, mon_cur.addr});
        check("bus_wdata", ifc.bus_wdata, mon_cur.wdata);
      end
    end else if (ifc.bus_req === 1'b1) begin
      check("bus_addr_hold", {2'b00, ifc.bus_addr}, {2'b00, mon_cur.addr});
      check("bus_wdata_hold", ifc.bus_wdata, mon_cur.wdata);
      check("bus_rw_hold", {31'h0, ifc.bus_rw}, {31'h0, mon_cur.rw});
    end
    mon_prev = (ifc.bus_req === 1'b1);
  end

  // One complete access from a single requester, with latency/busy checks.
  task automatic run_access(input vec_t v);
    int          rdy_c;
    logic        rdy;
    logic        busy;
    logic [31:0] rd;
    rdy_c = -1;
    @(negedge clk);
    bus_waits = v.waits;
    bus_resp  = v.rdata;
    bus_stall = 1'b0;
    if (v.is_mem) begin
      ifc.mem_req = 1'b1; ifc.mem_rw = v.rw; ifc.mem_addr = v.addr; ifc.mem_wdata = v.wdata;
      push_exp(v.rw, v.addr, v.wdata);
    end else begin
      ifc.if_req = 1'b1; ifc.if_addr = v.addr;
      push_exp(BUS_READ, v.addr, 32'h0);
    end
    for (int c = 0; c < 32 && rdy_c < 0; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      rdy  = v.is_mem ? ifc.mem_rdy   : ifc.if_rdy;
      busy = v.is_mem ? ifc.mem_busy  : ifc.if_busy;
      rd   = v.is_mem ? ifc.mem_rdata : ifc.if_rdata;
      if (rdy === 1'b1) begin
        rdy_c = c;
        check("rdata", rd, v.rdata);
        check("busy_at_rdy", {31'h0, busy}, 32'h0);
      end else begin
        check("busy_waiting", {31'h0, busy}, 32'h1);
      end
    end
    check("rdy_latency", rdy_c, v.exp_lat);
    @(negedge clk);
    ifc.mem_req = 1'b0;
    ifc.if_req  = 1'b0;
    #1;
    rdy = v.is_mem ? ifc.mem_rdy : ifc.if_rdy;
    check("rdy_single_pulse", {31'h0, rdy}, 32'h0);
    check("bus_req_after", {31'h0, ifc.bus_req}, 32'h0);
  endtask

  vec_t vecs[5];

  initial begin
    int mem_c;
    int if_c;
    int brdy_c;

    vecs[0] = '{1'b0, BUS_READ,  30'h10,       32'h0,         0,      32'h1234_5678, 1};
    vecs[1] = '{1'b1, BUS_READ,  30'h80,       32'h0,         1,      32'hA5A5_0F0F, 2};
    vecs[2] = '{1'b1, BUS_WRITE, 30'h40,       32'hDEAD_BEEF, 0,      32'h0000_0000, 1};
    vecs[3] = '{1'b1, BUS_WRITE, 30'h3FFF_FFFF, 32'h0BAD_F00D, LONG_W, 32'h7777_0001, 1 + LONG_W};
    vecs[4] = '{1'b0, BUS_READ,  30'h0,        32'h0,         2,      32'hFFFF_FFFF, 3};

    rst = 1'b1;
    ifc.if_req = 1'b0; ifc.if_addr = '0; ifc.if_flush = 1'b0;
    ifc.mem_req = 1'b0; ifc.mem_rw = 1'b0; ifc.mem_addr = '0; ifc.mem_wdata = '0;
    ifc.bus_rdy = 1'b0; ifc.bus_rdata = '0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    ifc.bus_rdata = 32'h0000_5A5A;
    #1;
    check("rst_bus_req",   {31'h0, ifc.bus_req}, 32'h0);
    check("rst_bus_rw",    {31'h0, ifc.bus_rw},  32'h0);
    check("rst_bus_addr",  {2'b00, ifc.bus_addr}, 32'h0);
    check("rst_bus_wdata", ifc.bus_wdata, 32'h0);
    check("rst_if_rdy",    {31'h0, ifc.if_rdy},  32'h0);
    check("rst_mem_rdy",   {31'h0, ifc.mem_rdy}, 32'h0);
    check("rst_bus_err",   {31'h0, ifc.bus_err}, 32'h0);
    check("rdata_passthru", ifc.if_rdata, 32'h0000_5A5A);
    @(negedge clk);
    rst = 1'b0;

    // ---- table of single accesses ----
    for (int i = 0; i < 5; i++) run_access(vecs[i]);

    // ---- contention: MEM first, IF after one IDLE cycle ----
    @(negedge clk);
    mem_c = -1; if_c = -1;
    bus_waits = 0; bus_resp = 32'h1111_2222; bus_stall = 1'b0;
    ifc.mem_req = 1'b1; ifc.mem_rw = BUS_WRITE; ifc.mem_addr = 30'h40; ifc.mem_wdata = 32'hDEAD_BEEF;
    ifc.if_req = 1'b1; ifc.if_addr = 30'h44;
    push_exp(BUS_WRITE, 30'h40, 32'hDEAD_BEEF);
    push_exp(BUS_READ, 30'h44, 32'h0);
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      if (mem_c >= 0 && c == mem_c + 1) ifc.mem_req = 1'b0;
      if (if_c >= 0 && c == if_c + 1) ifc.if_req = 1'b0;
      #1;
      if (ifc.mem_rdy === 1'b1) mem_c = c;
      if (ifc.if_rdy === 1'b1) if_c = c;
      if (c == 2) check("contend_idle_gap", {31'h0, ifc.bus_req}, 32'h0);
      if (if_c < 0) check("contend_if_busy", {31'h0, ifc.if_busy}, 32'h1);
    end
    check("contend_mem_rdy_cyc", mem_c, 32'd1);
    check("contend_if_rdy_cyc", if_c, 32'd3);

    // ---- flush in flight: bus cycle completes, if_rdy swallowed ----
    @(negedge clk);
    brdy_c = -1;
    bus_waits = 3; bus_resp = 32'hCAFE_BABE;
    ifc.if_req = 1'b1; ifc.if_addr = 30'h88;
    push_exp(BUS_READ, 30'h88, 32'h0);
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1) begin ifc.if_flush = 1'b1; ifc.if_req = 1'b0; end
      if (c == 2) ifc.if_flush = 1'b0;
      #1;
      if (ifc.bus_rdy === 1'b1) brdy_c = c;
      check("flush_if_rdy_low", {31'h0, ifc.if_rdy}, 32'h0);
      if (c == 5) check("flush_back_idle", {31'h0, ifc.bus_req}, 32'h0);
    end
    check("flush_bus_completed", brdy_c, 32'd4);

    // ---- flush coinciding with bus_rdy ----
    @(negedge clk);
    bus_waits = 1; bus_resp = 32'h0F0F_0F0F;
    ifc.if_req = 1'b1; ifc.if_addr = 30'h90;
    push_exp(BUS_READ, 30'h90, 32'h0);
    repeat (2) @(negedge clk);
    ifc.if_flush = 1'b1;
    #1;
    check("flush_rdy_bus_rdy", {31'h0, ifc.bus_rdy}, 32'h1);
    check("flush_rdy_if_rdy", {31'h0, ifc.if_rdy}, 32'h0);
    @(negedge clk);
    ifc.if_flush = 1'b0; ifc.if_req = 1'b0;
    #1;
    check("flush_rdy_idle", {31'h0, ifc.bus_req}, 32'h0);

    // ---- flush in IDLE blocks the grant for that cycle ----
    @(negedge clk);
    bus_waits = 0; bus_resp = 32'h2468_ACE0;
    ifc.if_req = 1'b1; ifc.if_flush = 1'b1; ifc.if_addr = 30'h94;
    push_exp(BUS_READ, 30'h94, 32'h0);
    @(negedge clk);
    ifc.if_flush = 1'b0;
    #1;
    check("idle_flush_no_grant", {31'h0, ifc.bus_req}, 32'h0);
    check("idle_flush_busy", {31'h0, ifc.if_busy}, 32'h1);
    @(negedge clk);
    #1;
    check("idle_flush_then_rdy", {31'h0, ifc.if_rdy}, 32'h1);
    check("idle_flush_rdata", ifc.if_rdata, 32'h2468_ACE0);
    @(negedge clk);
    ifc.if_req = 1'b0;

    // ---- reset mid-access, then a normal access ----
    @(negedge clk);
    bus_stall = 1'b1;
    ifc.mem_req = 1'b1; ifc.mem_rw = BUS_READ; ifc.mem_addr = 30'h100; ifc.mem_wdata = 32'h0;
    push_exp(BUS_READ, 30'h100, 32'h0);
    repeat (2) @(negedge clk);
    #1;
    check("rstmid_in_access", {31'h0, ifc.bus_req}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rstmid_bus_req", {31'h0, ifc.bus_req}, 32'h0);
    check("rstmid_mem_rdy", {31'h0, ifc.mem_rdy}, 32'h0);
    rst = 1'b0; ifc.mem_req = 1'b0; bus_stall = 1'b0;
    run_access('{1'b1, BUS_READ, 30'h104, 32'h0, 0, 32'h5555_AAAA, 1});

`ifdef IF_MEM_ARB_TIMEOUT_EN
    // ---- watchdog: bus never answers ----
    @(negedge clk);
    bus_stall = 1'b1;
    ifc.bus_rdata = 32'hFFFF_FFFF;
    ifc.if_req = 1'b1; ifc.if_addr = 30'h20;
    push_exp(BUS_READ, 30'h20, 32'h0);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      #1;
      if (c < 4) begin
        check("wd_no_err_early", {31'h0, ifc.bus_err}, 32'h0);
        check("wd_no_rdy_early", {31'h0, ifc.if_rdy}, 32'h0);
      end else if (c == 4) begin
        check("wd_bus_err", {31'h0, ifc.bus_err}, 32'h1);
        check("wd_if_rdy", {31'h0, ifc.if_rdy}, 32'h1);
        check("wd_if_rdata_zero", ifc.if_rdata, 32'h0);
        ifc.if_req = 1'b0;
      end else begin
        check("wd_idle", {31'h0, ifc.bus_req}, 32'h0);
        check("wd_err_pulse", {31'h0, ifc.bus_err}, 32'h0);
      end
    end
    bus_stall = 1'b0;
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
